// File: rtl/display_owner_arbiter_if.sv
// Bus bundle between the three display requesters and display_owner_arbiter.
// Handshake: req[i] is a level held high for as long as requester i wants the
// display; grant is one-hot and names the current owner. There is no ack or
// ready: a requester owns the scan exactly while its grant bit is 1, and a
// requester drops ownership simply by lowering req[i].
// dbg_state mirrors the arbiter FSM state (0=IDLE, 1=OWN, 2=GAP).
interface display_owner_arbiter_if;
    logic [2:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [7:0]  mask0;
    logic [7:0]  mask1;
    logic [7:0]  mask2;
    logic [2:0]  grant;
    logic        busy;
    logic [2:0]  cell_idx;
    logic [7:0]  cell_anode;
    logic [3:0]  cell_bcd;
    logic        frame_tick;
    logic [1:0]  dbg_state;

    modport master (
        output req, data0, data1, data2, mask0, mask1, mask2,
        input  grant, busy, cell_idx, cell_anode, cell_bcd, frame_tick, dbg_state
    );

    modport slave (
        input  req, data0, data1, data2, mask0, mask1, mask2,
        output grant, busy, cell_idx, cell_anode, cell_bcd, frame_tick, dbg_state
    );
endinterface

// File: rtl/display_owner_arbiter.sv
// display_owner_arbiter: shares one 8-cell 7-segment scan between an emergency
// alert (0), a countdown timer (1) and a keypad echo (2). Fixed priority, a
// minimum ownership hold, a one-cycle blank gap on every handover, and a frame
// latch that only refreshes at the end of a scan frame.
// Optional feature macro: DISP_BLINK_EN (blinks the emergency owner's anodes).
module display_owner_arbiter #(
    parameter int unsigned HOLD_CYC   = 16,
    parameter int unsigned BLINK_HALF = 256
) (
    input  logic                     clk_mux,
    input  logic                     rst,
    display_owner_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       frame_q, frame_d;
    logic [7:0]        fmask_q, fmask_d;
    logic [2:0]        cell_idx_q, cell_idx_d;

    logic [1:0]  winner;
    logic [31:0] win_data, own_data;
    logic [7:0]  win_mask, own_mask;
    logic        owner_req, higher_req, go_gap, frame_tick, enter_own, blink_off;

    // Arbitration helpers: winner of a fresh arbitration and the current owner's sources.
    always_comb begin
        winner = req_winner(bus.req);
        win_data = 32'h0;
        win_mask = 8'h00;
        own_data = 32'h0;
        own_mask = 8'h00;
        owner_req  = 1'b0;
        higher_req = 1'b0;
        case (winner)
            2'd0:    begin win_data = bus.data0; win_mask = bus.mask0; end
            2'd1:    begin win_data = bus.data1; win_mask = bus.mask1; end
            default: begin win_data = bus.data2; win_mask = bus.mask2; end
        endcase
        case (owner_q)
            2'd0: begin own_data = bus.data0; own_mask = bus.mask0; owner_req = bus.req[0]; end
            2'd1: begin own_data = bus.data1; own_mask = bus.mask1; owner_req = bus.req[1];
                        higher_req = bus.req[0]; end
            2'd2: begin own_data = bus.data2; own_mask = bus.mask2; owner_req = bus.req[2];
                        higher_req = bus.req[0] | bus.req[1]; end
            default: ;
        endcase
    end

    function automatic logic [1:0] req_winner(input logic [2:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    assign frame_tick = (cell_idx_q == 3'd7);

    // Release, emergency preemption, or an expired hold with a higher request waiting.
    assign go_gap = !owner_req
                  || (bus.req[0] && (owner_q != 2'd0))
                  || ((hold_q == '0) && higher_req);

    // Next-state logic for the ownership FSM, hold counter, frame latch and scan counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_d     = hold_q;
        frame_d    = frame_q;
        fmask_d    = fmask_q;
        cell_idx_d = cell_idx_q + 3'd1;
        case (state_q)
            ST_OWN: begin
                hold_d = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
                if (go_gap) begin
                    state_d = ST_GAP;
                end else if (frame_tick) begin
                    frame_d = own_data;
                    fmask_d = own_mask;
                end
            end
            default: begin
                // IDLE and GAP both arbitrate, so a handover costs exactly one blank cycle.
                if (|bus.req) begin
                    state_d = ST_OWN;
                    owner_d = winner;
                    frame_d = win_data;
                    fmask_d = win_mask;
                    hold_d  = HOLD_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign enter_own = (state_d == ST_OWN) && (state_q != ST_OWN);

    // State registers; reset drops the grant immediately.
    always_ff @(posedge clk_mux or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 2'd0;
            hold_q     <= '0;
            frame_q    <= 32'h0;
            fmask_q    <= 8'h00;
            cell_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            frame_q    <= frame_d;
            fmask_q    <= fmask_d;
            cell_idx_q <= cell_idx_d;
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;

    // Blink half-period counter, restarted on every new ownership.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
        phase_d     = phase_q;
        if (enter_own) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Blink registers.
    always_ff @(posedge clk_mux or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_off = (owner_q == 2'd0) && phase_q;
`else
    // Without blinking the emergency owner is shown steadily.
    if (BLINK_HALF == 0) begin : g_blink_unused
    end
    assign blink_off = 1'b0 & enter_own;
`endif

    // Outputs decoded from registered state.
    always_comb begin
        bus.grant      = 3'b000;
        bus.cell_anode = 8'hFF;
        bus.cell_bcd   = 4'hF;
        if (state_q == ST_OWN) begin
            bus.grant = 3'b001 << owner_q;
            if (fmask_q[cell_idx_q]) begin
                bus.cell_bcd = frame_q[cell_idx_q*4 +: 4];
                if (!blink_off) begin
                    bus.cell_anode = ~(8'b1 << cell_idx_q);
                end
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.cell_idx   = cell_idx_q;
    assign bus.frame_tick = frame_tick;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_display_owner_arbiter.sv
// Directed bench for display_owner_arbiter: reset, single owner scan, hold and
// preemption, release, frame latch timing and (when built with DISP_BLINK_EN)
// the emergency blink.
module tb_display_owner_arbiter;

    logic       clk_mux = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] sc;

    display_owner_arbiter_if bus();

    display_owner_arbiter #(.HOLD_CYC(16), .BLINK_HALF(4)) dut (
        .clk_mux (clk_mux),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_mux = ~clk_mux;

    task automatic step();
        @(posedge clk_mux);
        #1;
        sc = sc + 3'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 3'b000;
        bus.data0 = 32'h0; bus.data1 = 32'h0; bus.data2 = 32'h0;
        bus.mask0 = 8'h00; bus.mask1 = 8'h00; bus.mask2 = 8'h00;
        #22;
        checks++;
        if ({bus.grant, bus.busy, bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick, bus.dbg_state}
            !== {3'b000, 1'b0, 3'd0, 8'hFF, 4'hF, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values: got grant=%b busy=%b idx=%0d an=%h bcd=%h ft=%b st=%0d",
                     bus.grant, bus.busy, bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick, bus.dbg_state);
        end
        @(negedge clk_mux);
        rst = 1'b0;
        sc = 3'd0;
        step();
        checks++;
        if (bus.cell_idx !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_edge_idx: got %0d expected 1", bus.cell_idx);
        end
    endtask

    task automatic test_single_owner();
        bus.data2 = 32'h12345678;
        bus.mask2 = 8'hFF;
        bus.req = 3'b100;
        step();
        checks++;
        if ({bus.grant, bus.busy} !== {3'b100, 1'b1}) begin
            errors++;
            $display("FAIL single_grant: got grant=%b busy=%b expected 100/1", bus.grant, bus.busy);
        end
        for (int i = 0; i < 8 && sc != 3'd0; i++) step();
        checks++;
        if ({bus.cell_idx, bus.cell_anode, bus.cell_bcd} !== {3'd0, 8'hFE, 4'h8}) begin
            errors++;
            $display("FAIL single_cell0: got idx=%0d an=%h bcd=%h expected 0/FE/8", bus.cell_idx, bus.cell_anode, bus.cell_bcd);
        end
        for (int i = 0; i < 8 && sc != 3'd7; i++) step();
        checks++;
        if ({bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick} !== {3'd7, 8'h7F, 4'h1, 1'b1}) begin
            errors++;
            $display("FAIL single_cell7: got idx=%0d an=%h bcd=%h ft=%b expected 7/7F/1/1",
                     bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick);
        end
    endtask

    task automatic test_reset_mid_own();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.grant, bus.busy, bus.cell_anode, bus.cell_bcd} !== {3'b000, 1'b0, 8'hFF, 4'hF}) begin
            errors++;
            $display("FAIL reset_mid_own: got grant=%b busy=%b an=%h bcd=%h expected 000/0/FF/F",
                     bus.grant, bus.busy, bus.cell_anode, bus.cell_bcd);
        end
        bus.req = 3'b000;
        @(negedge clk_mux);
        rst = 1'b0;
        sc = 3'd0;
        #1;
        checks++;
        if (bus.cell_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_idx0: got %0d expected 0", bus.cell_idx);
        end
        step();
        checks++;
        if ({bus.cell_idx, bus.grant} !== {3'd1, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid_idx1: got idx=%0d grant=%b expected 1/000", bus.cell_idx, bus.grant);
        end
    endtask

    task automatic test_hold_preempt();
        bus.data1 = 32'h00000000;
        bus.mask1 = 8'hFF;
        bus.req = 3'b100;
        step();
        repeat (5) step();
        bus.req = 3'b110;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (bus.grant !== 3'b100) begin
                errors++;
                $display("FAIL hold_keeps_owner cycle %0d: got %b expected 100", i, bus.grant);
            end
        end
        step();
        checks++;
        if ({bus.grant, bus.busy, bus.cell_anode} !== {3'b000, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL hold_gap: got grant=%b busy=%b an=%h expected 000/1/FF", bus.grant, bus.busy, bus.cell_anode);
        end
        step();
        checks++;
        if (bus.grant !== 3'b010) begin
            errors++;
            $display("FAIL hold_new_owner: got %b expected 010", bus.grant);
        end
    endtask

    task automatic test_emergency_release();
        bus.mask0 = 8'hFF;
        step();
        bus.req = 3'b111;
        step();
        checks++;
        if ({bus.grant, bus.busy} !== {3'b000, 1'b1}) begin
            errors++;
            $display("FAIL emerg_gap: got grant=%b busy=%b expected 000/1", bus.grant, bus.busy);
        end
        step();
        checks++;
        if (bus.grant !== 3'b001) begin
            errors++;
            $display("FAIL emerg_grant: got %b expected 001", bus.grant);
        end
        bus.req = 3'b110;
        step();
        checks++;
        if (bus.grant !== 3'b000) begin
            errors++;
            $display("FAIL release_gap: got %b expected 000", bus.grant);
        end
        step();
        checks++;
        if (bus.grant !== 3'b010) begin
            errors++;
            $display("FAIL release_regrant: got %b expected 010", bus.grant);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.grant !== 3'b010) begin
                errors++;
                $display("FAIL low_no_preempt cycle %0d: got %b expected 010", i, bus.grant);
            end
        end
        bus.req = 3'b101;
        step();
        checks++;
        if (bus.grant !== 3'b000) begin
            errors++;
            $display("FAIL simul_gap: got %b expected 000", bus.grant);
        end
        step();
        checks++;
        if (bus.grant !== 3'b001) begin
            errors++;
            $display("FAIL simul_winner: got %b expected 001", bus.grant);
        end
        bus.req = 3'b000;
        step();
        step();
        checks++;
        if ({bus.grant, bus.busy, bus.dbg_state} !== {3'b000, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL back_to_idle: got grant=%b busy=%b st=%0d expected 000/0/0", bus.grant, bus.busy, bus.dbg_state);
        end
    endtask

    task automatic test_frame_update();
        logic [31:0] old_data, new_data, latched;
        logic [7:0]  exp_an;
        logic [3:0]  exp_bcd;
        old_data = 32'h87654321;
        new_data = 32'h0000CBA9;
        bus.data1 = old_data;
        bus.mask1 = 8'h0F;
        bus.req = 3'b010;
        step();
        for (int i = 0; i < 8 && sc != 3'd2; i++) step();
        checks++;
        if ({bus.grant, bus.cell_anode, bus.cell_bcd} !== {3'b010, 8'hFB, 4'h3}) begin
            errors++;
            $display("FAIL frame_before_change: got grant=%b an=%h bcd=%h expected 010/FB/3", bus.grant, bus.cell_anode, bus.cell_bcd);
        end
        bus.data1 = new_data;
        latched = old_data;
        for (int i = 0; i < 14; i++) begin
            step();
            if (sc == 3'd0) latched = new_data;
            exp_an  = (sc < 3'd4) ? ~(8'b1 << sc) : 8'hFF;
            exp_bcd = (sc < 3'd4) ? latched[sc*4 +: 4] : 4'hF;
            checks++;
            if ({bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick} !== {sc, exp_an, exp_bcd, (sc == 3'd7)}) begin
                errors++;
                $display("FAIL frame_latch step %0d: got idx=%0d an=%h bcd=%h ft=%b expected %0d/%h/%h/%b",
                         i, bus.cell_idx, bus.cell_anode, bus.cell_bcd, bus.frame_tick, sc, exp_an, exp_bcd, (sc == 3'd7));
            end
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    task automatic test_emergency_display();
        logic [7:0] exp_an;
        bus.data0 = 32'h76543210;
        bus.mask0 = 8'hFF;
        bus.req = 3'b001;
        for (int i = 0; i < 16; i++) begin
            step();
`ifdef DISP_BLINK_EN
            exp_an = (((i / 4) % 2) == 1) ? 8'hFF : ~(8'b1 << sc);
`else
            exp_an = ~(8'b1 << sc);
`endif
            checks++;
            if ({bus.grant, bus.cell_anode, bus.cell_bcd} !== {3'b001, exp_an, {1'b0, sc}}) begin
                errors++;
                $display("FAIL emerg_display cycle %0d: got grant=%b an=%h bcd=%h expected 001/%h/%h",
                         i, bus.grant, bus.cell_anode, bus.cell_bcd, exp_an, {1'b0, sc});
            end
        end
        bus.req = 3'b000;
        step();
        step();
    endtask

    initial begin
        sc = 3'd0;
        test_reset();
        test_single_owner();
        test_reset_mid_own();
        test_hold_preempt();
        test_emergency_release();
        test_frame_update();
        test_emergency_display();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
